// File: rtl/axi_regs_pkg.sv
// Shared response codes, index classification and address helpers for the
// AXI4-Lite config/status register bank.
package axi_regs_pkg;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      IDX_CONFIG,
      IDX_STATUS,
      IDX_ILLEGAL
   } idx_class_e;

   // Number of byte-offset bits dropped from an address to form a word index.
   function automatic int unsigned addr_lsb(input int unsigned data_width);
      return $clog2(data_width / 8);
   endfunction

   function automatic idx_class_e classify_idx(input int unsigned idx,
                                               input int unsigned num_config,
                                               input int unsigned num_status);
      if (idx < num_config) begin
         return IDX_CONFIG;
      end else if (idx < num_config + num_status) begin
         return IDX_STATUS;
      end
      return IDX_ILLEGAL;
   endfunction

endpackage

// File: rtl/axi_lite_wr_collector.sv
// Collects AXI4-Lite AW and W beats independently, issues one commit strobe
// once both are held, and owns the B response channel.
module axi_lite_wr_collector
   import axi_regs_pkg::*;
#(
   parameter int unsigned AXI_ADDR_WIDTH = 8,
   parameter int unsigned AXI_DATA_WIDTH = 32,
   parameter int unsigned NUM_CONFIG     = 16,
   parameter int unsigned NUM_STATUS     = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [AXI_ADDR_WIDTH-1:0]     s_awaddr,
   input  logic                          s_awvalid,
   output logic                          s_awready,
   input  logic [AXI_DATA_WIDTH-1:0]     s_wdata,
   input  logic [AXI_DATA_WIDTH/8-1:0]   s_wstrb,
   input  logic                          s_wvalid,
   output logic                          s_wready,
   output logic [1:0]                    s_bresp,
   output logic                          s_bvalid,
   input  logic                          s_bready,
   output logic                          commit_o,
   output idx_class_e                    commit_class_o,
   output logic [AXI_ADDR_WIDTH-1:0]     commit_addr_o,
   output logic [AXI_DATA_WIDTH-1:0]     commit_data_o,
   output logic [AXI_DATA_WIDTH/8-1:0]   commit_strb_o
);

   localparam int unsigned ADDR_LSB = addr_lsb(AXI_DATA_WIDTH);

   logic                        aw_held_q, aw_held_d;
   logic                        w_held_q,  w_held_d;
   logic [AXI_ADDR_WIDTH-1:0]   awaddr_q,  awaddr_d;
   logic [AXI_DATA_WIDTH-1:0]   wdata_q,   wdata_d;
   logic [AXI_DATA_WIDTH/8-1:0] wstrb_q,   wstrb_d;
   logic                        bvalid_q,  bvalid_d;
   logic [1:0]                  bresp_q,   bresp_d;

   logic aw_hs;
   logic w_hs;
   logic commit;

   always_comb begin
      s_awready      = !aw_held_q && !bvalid_q;
      s_wready       = !w_held_q && !bvalid_q;
      aw_hs          = s_awvalid && s_awready;
      w_hs           = s_wvalid && s_wready;
      commit         = aw_held_q && w_held_q;
      commit_o       = commit;
      commit_class_o = classify_idx(32'(awaddr_q >> ADDR_LSB), NUM_CONFIG, NUM_STATUS);
      commit_addr_o  = awaddr_q;
      commit_data_o  = wdata_q;
      commit_strb_o  = wstrb_q;
      s_bvalid       = bvalid_q;
      s_bresp        = bresp_q;
   end

   always_comb begin
      aw_held_d = aw_held_q;
      w_held_d  = w_held_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      if (aw_hs) begin
         aw_held_d = 1'b1;
         awaddr_d  = s_awaddr;
      end
      if (w_hs) begin
         w_held_d = 1'b1;
         wdata_d  = s_wdata;
         wstrb_d  = s_wstrb;
      end
      if (bvalid_q && s_bready) begin
         bvalid_d = 1'b0;
      end
      // Both ready flags are low while both beats are held, so no capture can
      // coincide with a commit.
      if (commit) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = (commit_class_o == IDX_CONFIG) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= AXI_RESP_OKAY;
      end else begin
         aw_held_q <= aw_held_d;
         w_held_q  <= w_held_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
      end
   end

endmodule

// File: rtl/axi_config_status_regs.sv
// AXI4-Lite register bank: NUM_CONFIG byte-writable config registers with
// write pulses, followed by NUM_STATUS read-only status words from fabric.
module axi_config_status_regs
   import axi_regs_pkg::*;
#(
   parameter int unsigned AXI_ADDR_WIDTH = 8,
   parameter int unsigned AXI_DATA_WIDTH = 32,
   parameter int unsigned NUM_CONFIG     = 16,
   parameter int unsigned NUM_STATUS     = 8,
   parameter logic [NUM_CONFIG*AXI_DATA_WIDTH-1:0] CONFIG_RESET = '0
) (
   input  logic                                  S_AXI_ACLK,
   input  logic                                  S_AXI_ARESET,
   input  logic [AXI_ADDR_WIDTH-1:0]             S_AXI_AWADDR,
   input  logic [2:0]                            S_AXI_AWPROT,
   input  logic                                  S_AXI_AWVALID,
   output logic                                  S_AXI_AWREADY,
   input  logic [AXI_DATA_WIDTH-1:0]             S_AXI_WDATA,
   input  logic [AXI_DATA_WIDTH/8-1:0]           S_AXI_WSTRB,
   input  logic                                  S_AXI_WVALID,
   output logic                                  S_AXI_WREADY,
   output logic [1:0]                            S_AXI_BRESP,
   output logic                                  S_AXI_BVALID,
   input  logic                                  S_AXI_BREADY,
   input  logic [AXI_ADDR_WIDTH-1:0]             S_AXI_ARADDR,
   input  logic [2:0]                            S_AXI_ARPROT,
   input  logic                                  S_AXI_ARVALID,
   output logic                                  S_AXI_ARREADY,
   output logic [AXI_DATA_WIDTH-1:0]             S_AXI_RDATA,
   output logic [1:0]                            S_AXI_RRESP,
   output logic                                  S_AXI_RVALID,
   input  logic                                  S_AXI_RREADY,
   output logic [NUM_CONFIG*AXI_DATA_WIDTH-1:0]  config_out,
   output logic [NUM_CONFIG-1:0]                 config_wr_pulse,
   input  logic [((NUM_STATUS > 0) ? NUM_STATUS : 1)*AXI_DATA_WIDTH-1:0] status_in
);

   localparam int unsigned ADDR_LSB = addr_lsb(AXI_DATA_WIDTH);
   localparam int unsigned DW       = AXI_DATA_WIDTH;

   logic [DW-1:0]         config_q [NUM_CONFIG];
   logic [DW-1:0]         config_d [NUM_CONFIG];
   logic [NUM_CONFIG-1:0] wr_pulse_q, wr_pulse_d;
   logic                  rvalid_q, rvalid_d;
   logic [DW-1:0]         rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;

   logic                  commit;
   idx_class_e            commit_class;
   logic [AXI_ADDR_WIDTH-1:0] commit_addr;
   logic [DW-1:0]         commit_data;
   logic [DW/8-1:0]       commit_strb;
   int unsigned           wr_idx;

   logic                  ar_hs;
   int unsigned           rd_idx;
   idx_class_e            rd_class;
   logic [DW-1:0]         rd_word;

   logic                  unused_prot;
   assign unused_prot = ^{S_AXI_ARPROT, S_AXI_AWPROT};

   axi_lite_wr_collector #(
      .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
      .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
      .NUM_CONFIG     (NUM_CONFIG),
      .NUM_STATUS     (NUM_STATUS)
   ) u_wr_collector (
      .clk            (S_AXI_ACLK),
      .rst            (S_AXI_ARESET),
      .s_awaddr       (S_AXI_AWADDR),
      .s_awvalid      (S_AXI_AWVALID),
      .s_awready      (S_AXI_AWREADY),
      .s_wdata        (S_AXI_WDATA),
      .s_wstrb        (S_AXI_WSTRB),
      .s_wvalid       (S_AXI_WVALID),
      .s_wready       (S_AXI_WREADY),
      .s_bresp        (S_AXI_BRESP),
      .s_bvalid       (S_AXI_BVALID),
      .s_bready       (S_AXI_BREADY),
      .commit_o       (commit),
      .commit_class_o (commit_class),
      .commit_addr_o  (commit_addr),
      .commit_data_o  (commit_data),
      .commit_strb_o  (commit_strb)
   );

   always_comb begin
      wr_idx = 32'(commit_addr >> ADDR_LSB);
      config_d   = config_q;
      wr_pulse_d = '0;
      if (commit && (commit_class == IDX_CONFIG)) begin
         for (int unsigned k = 0; k < NUM_CONFIG; k++) begin
            if (wr_idx == k) begin
               wr_pulse_d[k] = 1'b1;
               for (int unsigned b = 0; b < DW/8; b++) begin
                  if (commit_strb[b]) begin
                     config_d[k][b*8 +: 8] = commit_data[b*8 +: 8];
                  end
               end
            end
         end
      end
   end

   // Read mux uses pre-edge config contents, so a read that coincides with a
   // commit returns the old value.
   always_comb begin
      ar_hs    = S_AXI_ARVALID && !rvalid_q;
      rd_idx   = 32'(S_AXI_ARADDR >> ADDR_LSB);
      rd_class = classify_idx(rd_idx, NUM_CONFIG, NUM_STATUS);
      rd_word  = '0;
      for (int unsigned k = 0; k < NUM_CONFIG; k++) begin
         if (rd_idx == k) begin
            rd_word = config_q[k];
         end
      end
      for (int unsigned s = 0; s < NUM_STATUS; s++) begin
         if (rd_idx == NUM_CONFIG + s) begin
            rd_word = status_in[s*DW +: DW];
         end
      end
   end

   always_comb begin
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      if (rvalid_q && S_AXI_RREADY) begin
         rvalid_d = 1'b0;
      end
      if (ar_hs) begin
         rvalid_d = 1'b1;
         if (rd_class == IDX_ILLEGAL) begin
            rdata_d = '0;
            rresp_d = AXI_RESP_SLVERR;
         end else begin
            rdata_d = rd_word;
            rresp_d = AXI_RESP_OKAY;
         end
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         for (int unsigned k = 0; k < NUM_CONFIG; k++) begin
            config_q[k] <= CONFIG_RESET[k*DW +: DW];
         end
         wr_pulse_q <= '0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= AXI_RESP_OKAY;
      end else begin
         config_q   <= config_d;
         wr_pulse_q <= wr_pulse_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
      end
   end

   always_comb begin
      config_out = '0;
      for (int unsigned k = 0; k < NUM_CONFIG; k++) begin
         config_out[k*DW +: DW] = config_q[k];
      end
      config_wr_pulse = wr_pulse_q;
      S_AXI_ARREADY   = !rvalid_q;
      S_AXI_RVALID    = rvalid_q;
      S_AXI_RDATA     = rdata_q;
      S_AXI_RRESP     = rresp_q;
   end

endmodule

// File: tb/tb_axi_config_status_regs.sv
// Scoreboard bench for axi_config_status_regs: stimulus queues expected R/B
// responses, an independent monitor pops and compares on each handshake.
module tb_axi_config_status_regs;

   localparam int NC = 16;
   localparam int NS = 8;

   function automatic logic [NC*32-1:0] mk_img();
      logic [NC*32-1:0] v;
      v = '0;
      v[0*32 +: 32] = 32'h0000_5A5A;
      v[1*32 +: 32] = 32'hFFFF_FFFF;
      v[3*32 +: 32] = 32'hDEAD_BEEF;
      return v;
   endfunction
   localparam logic [NC*32-1:0] RST_IMG = mk_img();

   logic              clk = 1'b0;
   logic              rst;
   logic [7:0]        awaddr, araddr;
   logic [2:0]        awprot, arprot;
   logic              awvalid, awready, wvalid, wready, bvalid, bready;
   logic              arvalid, arready, rvalid, rready;
   logic [31:0]       wdata, rdata;
   logic [3:0]        wstrb;
   logic [1:0]        bresp, rresp;
   logic [NC*32-1:0]  config_out;
   logic [NC-1:0]     config_wr_pulse;
   logic [NS*32-1:0]  status_in;

   always #5 clk = ~clk;

   axi_config_status_regs #(
      .AXI_ADDR_WIDTH (8),
      .AXI_DATA_WIDTH (32),
      .NUM_CONFIG     (NC),
      .NUM_STATUS     (NS),
      .CONFIG_RESET   (RST_IMG)
   ) dut (
      .S_AXI_ACLK      (clk),
      .S_AXI_ARESET    (rst),
      .S_AXI_AWADDR    (awaddr),
      .S_AXI_AWPROT    (awprot),
      .S_AXI_AWVALID   (awvalid),
      .S_AXI_AWREADY   (awready),
      .S_AXI_WDATA     (wdata),
      .S_AXI_WSTRB     (wstrb),
      .S_AXI_WVALID    (wvalid),
      .S_AXI_WREADY    (wready),
      .S_AXI_BRESP     (bresp),
      .S_AXI_BVALID    (bvalid),
      .S_AXI_BREADY    (bready),
      .S_AXI_ARADDR    (araddr),
      .S_AXI_ARPROT    (arprot),
      .S_AXI_ARVALID   (arvalid),
      .S_AXI_ARREADY   (arready),
      .S_AXI_RDATA     (rdata),
      .S_AXI_RRESP     (rresp),
      .S_AXI_RVALID    (rvalid),
      .S_AXI_RREADY    (rready),
      .config_out      (config_out),
      .config_wr_pulse (config_wr_pulse),
      .status_in       (status_in)
   );

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
   } r_exp_t;

   r_exp_t     r_q[$];
   logic [1:0] b_q[$];
   int         tests  = 0;
   int         failed = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      tests++;
      failed++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   function automatic logic [31:0] cfg(input int k);
      return config_out[k*32 +: 32];
   endfunction

   // Monitor: samples on the falling edge, when a handshake is about to occur.
   always @(negedge clk) begin
      if (!rst) begin
         if (rvalid && rready) begin
            if (r_q.size() == 0) begin
               timeout_fail("r_unexpected_beat");
            end else begin
               r_exp_t e;
               e = r_q.pop_front();
               check("rdata", 64'(rdata), 64'(e.data));
               check("rresp", 64'(rresp), 64'(e.resp));
            end
         end
         if (bvalid && bready) begin
            if (b_q.size() == 0) begin
               timeout_fail("b_unexpected_beat");
            end else begin
               logic [1:0] eb;
               eb = b_q.pop_front();
               check("bresp", 64'(bresp), 64'(eb));
            end
         end
      end
   end

   // All stimulus tasks start and end at posedge+1.
   task automatic do_read(input logic [7:0] addr, input logic [31:0] exp_d, input logic [1:0] exp_r);
      r_exp_t e;
      e.data = exp_d;
      e.resp = exp_r;
      r_q.push_back(e);
      araddr  = addr;
      arvalid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (arready) begin
            @(posedge clk); #1;
            arvalid = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      arvalid = 1'b0;
      timeout_fail("ar_handshake");
   endtask

   task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int lead, input logic [1:0] exp_r);
      bit aw_done, w_done, aw_fire, w_fire;
      int cyc;
      b_q.push_back(exp_r);
      aw_done = 1'b0;
      w_done  = 1'b0;
      cyc     = 0;
      wdata   = data;
      wstrb   = strb;
      wvalid  = 1'b1;
      while (!(aw_done && w_done) && cyc < 40) begin
         if (cyc == lead && !aw_done) begin
            awaddr  = addr;
            awvalid = 1'b1;
         end
         @(negedge clk);
         aw_fire = awvalid && awready;
         w_fire  = wvalid && wready;
         @(posedge clk); #1;
         if (aw_fire) begin
            awvalid = 1'b0;
            aw_done = 1'b1;
         end
         if (w_fire) begin
            wvalid = 1'b0;
            w_done = 1'b1;
         end
         cyc++;
      end
      if (!(aw_done && w_done)) begin
         awvalid = 1'b0;
         wvalid  = 1'b0;
         timeout_fail("aw_w_handshake");
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (r_q.size() == 0 && b_q.size() == 0) return;
      end
      timeout_fail("response_drain");
      r_q.delete();
      b_q.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [NC-1:0] pulse_seen;
      rst = 1'b1;
      awaddr = '0; awprot = '0; awvalid = 1'b0;
      araddr = '0; arprot = '0; arvalid = 1'b0;
      wdata = '0; wstrb = '0; wvalid = 1'b0;
      bready = 1'b1; rready = 1'b1;
      status_in = '0;
      status_in[0*32 +: 32] = 32'h0000_00A5;
      status_in[7*32 +: 32] = 32'h7777_0007;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      check("rst_rvalid", 64'(rvalid), 64'h0);
      check("rst_bvalid", 64'(bvalid), 64'h0);
      check("rst_rdata", 64'(rdata), 64'h0);
      check("rst_rresp", 64'(rresp), 64'h0);
      check("rst_bresp", 64'(bresp), 64'h0);
      check("rst_readys", 64'({arready, awready, wready}), 64'h7);
      check("rst_pulse", 64'(config_wr_pulse), 64'h0);
      check("rst_cfg3", 64'(cfg(3)), 64'hDEAD_BEEF);
      check("rst_cfg1", 64'(cfg(1)), 64'hFFFF_FFFF);
      check("rst_cfg2", 64'(cfg(2)), 64'h0);
      @(posedge clk); #1;

      // Reset value readback, then last config index and last status index.
      do_read(8'h0C, 32'hDEAD_BEEF, 2'b00);
      do_read(8'h3C, 32'h0, 2'b00);
      do_read(8'h5C, 32'h7777_0007, 2'b00);
      drain();
      check("read_no_pulse", 64'(config_wr_pulse), 64'h0);

      // W leads AW by three cycles; check commit latency and pulse width.
      do_write(8'h08, 32'h1234_5678, 4'hF, 3, 2'b00);
      @(negedge clk);
      check("wr2_pre_cfg", 64'(cfg(2)), 64'h0);
      check("wr2_pre_pulse", 64'(config_wr_pulse), 64'h0);
      @(negedge clk);
      check("wr2_cfg", 64'(cfg(2)), 64'h1234_5678);
      check("wr2_pulse", 64'(config_wr_pulse), 64'h0004);
      @(negedge clk);
      check("wr2_pulse_end", 64'(config_wr_pulse), 64'h0);
      @(posedge clk); #1;
      drain();

      // Byte strobes onto an all-ones reset value.
      do_write(8'h04, 32'hAABB_CCDD, 4'b0101, 0, 2'b00);
      drain();
      check("strb_cfg1", 64'(cfg(1)), 64'hFFBB_FFDD);
      do_read(8'h04, 32'hFFBB_FFDD, 2'b00);
      do_write(8'h00, 32'hCAFE_0000, 4'hF, 0, 2'b00);
      drain();
      check("wr0_cfg0", 64'(cfg(0)), 64'hCAFE_0000);

      // Status region: readable, write rejected without side effects.
      do_read(8'h40, 32'h0000_00A5, 2'b00);
      drain();
      pulse_seen = '0;
      fork
         do_write(8'h40, 32'h5555_5555, 4'hF, 0, 2'b10);
         repeat (8) @(negedge clk) pulse_seen |= config_wr_pulse;
      join
      drain();
      check("status_wr_no_pulse", 64'(pulse_seen), 64'h0);
      do_read(8'h40, 32'h0000_00A5, 2'b00);
      do_write(8'h60, 32'h0123_4567, 4'hF, 0, 2'b10);
      drain();

      // Illegal read with the master stalling RREADY.
      rready = 1'b0;
      do_read(8'h60, 32'h0, 2'b10);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_rvalid", 64'(rvalid), 64'h1);
         check("stall_rdata", 64'(rdata), 64'h0);
         check("stall_rresp", 64'(rresp), 64'h2);
         check("stall_arready", 64'(arready), 64'h0);
      end
      @(posedge clk); #1;
      rready = 1'b1;
      drain();

      // Reset while only the address beat is held.
      awaddr  = 8'h00;
      awvalid = 1'b1;
      @(negedge clk);
      check("abort_aw_ready", 64'(awready), 64'h1);
      @(posedge clk); #1;
      awvalid = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("abort_cfg0", 64'(cfg(0)), 64'h0000_5A5A);
      check("abort_bvalid", 64'(bvalid), 64'h0);
      check("abort_awready", 64'(awready), 64'h1);
      check("abort_pulse", 64'(config_wr_pulse), 64'h0);
      @(posedge clk); #1;
      do_write(8'h00, 32'h1111_2222, 4'hF, 0, 2'b00);
      drain();
      check("post_abort_cfg0", 64'(cfg(0)), 64'h1111_2222);
      do_read(8'h00, 32'h1111_2222, 2'b00);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/axi_config_status_regs.md
Name: axi_config_status_regs

Overview:
- Parametrised AXI4-Lite slave register bank; successor to the fixed 8-register config block.
- Provides NUM_CONFIG read/write config registers with per-register reset values and NUM_STATUS read-only status registers sampled from fabric.
- Adds per-register write pulses, independent AW/W acceptance, SLVERR on illegal accesses, and reset of register contents.
- Sits between the PS AXI GP port (via interconnect) and PL sequencer/DSP cores.

Parameters:
- AXI_ADDR_WIDTH, 8, byte-address width.
- AXI_DATA_WIDTH, 32, data width; 32 or 64.
- NUM_CONFIG, 16, number of R/W config registers, 1..64.
- NUM_STATUS, 8, number of read-only status registers, 0..64.
- CONFIG_RESET, all zeros, flat NUM_CONFIG*AXI_DATA_WIDTH reset image; register k uses slice k.

Ports:
- S_AXI_ACLK  in  1  sole clock.
- S_AXI_ARESET  in  1  synchronous active-high reset.
- S_AXI_AR*/R*/AW*/W*/B*  standard AXI4-Lite slave channels, widths per parameters; ARPROT/AWPROT are ignored.
- config_out  out  NUM_CONFIG*AXI_DATA_WIDTH  flat config register contents; register k is slice k.
- config_wr_pulse  out  NUM_CONFIG  one-cycle pulse per register written.
- status_in  in  max(NUM_STATUS,1)*AXI_DATA_WIDTH  flat status words, synchronous to S_AXI_ACLK.

Behaviour:
- Decided: one clock; reset is synchronous and active-high.
- Register index: idx = addr >> log2(AXI_DATA_WIDTH/8); low byte-offset bits are ignored.
  - idx < NUM_CONFIG: config register.
  - NUM_CONFIG ≤ idx < NUM_CONFIG+NUM_STATUS: status register idx-NUM_CONFIG.
  - Otherwise: illegal.
- Reset values:
  - config_out = CONFIG_RESET; config_wr_pulse = 0.
  - RVALID = BVALID = 0; RDATA = 0; RRESP = BRESP = 0.
  - ARREADY = AWREADY = WREADY = 1.
  - Held flags cleared.
  - Reset mid-transaction aborts it; no register is updated.
- Read path:
  - ARREADY = !RVALID.
  - On the AR handshake edge, RDATA is registered and RVALID=1 from the next cycle.
  - Config index: current value. Status index: status_in slice sampled at that edge.
  - Illegal index: RDATA=0, RRESP=2'b10; otherwise RRESP=2'b00.
  - RDATA/RRESP are held stable until RVALID&RREADY; RVALID drops on that edge.
  - Back-to-back reads are possible at one transfer per 2 cycles.
- Write path (AW and W accepted independently, in either order or in the same cycle):
  - AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID.
  - Each handshake stores addr or data+strb and sets its held flag.
  - Edge on which aw_held && w_held is seen (commit):
    - legal config index: each byte with WSTRB set is updated; config_wr_pulse[idx]=1 for exactly the next cycle, even when WSTRB=0.
    - status or illegal index: no update, no pulse, BRESP=2'b10; else BRESP=2'b00.
    - BVALID=1 from the next cycle; both held flags are cleared.
  - BVALID drops on BVALID&BREADY. No new AW/W is accepted while BVALID=1.
  - Latency: final handshake at edge E0 -> config_out updated and BVALID high after E1.
- Simultaneous read and write to the same config register:
  - A read whose AR handshake coincides with the commit edge returns the old value.
  - A later read returns the new value.
- Channel independence: the read and write paths are independent; neither stalls the other.
- NUM_STATUS=0: status_in is a 1-word dummy; all indices ≥ NUM_CONFIG are illegal.

Decomposition:
- Package axi_regs_pkg holds:
  - AXI_RESP_OKAY=2'b00 and AXI_RESP_SLVERR=2'b10;
  - the function computing log2(AXI_DATA_WIDTH/8);
  - the index classification enum {IDX_CONFIG, IDX_STATUS, IDX_ILLEGAL}.
- One sub-module, axi_lite_wr_collector, owns AW/W capture, the held flags and the B channel. It emits a single commit strobe with addr/data/strb.
- The read path and register storage stay in the top module.

Test Plan:
- Reset with CONFIG_RESET slice 3 = 32'hDEAD_BEEF; read addr 0x0C -> RDATA=32'hDEADBEEF, RRESP=0; config_wr_pulse stays 0.
- Write addr 0x08 data 32'h1234_5678 with W presented 3 cycles before AW -> config slice 2 = 32'h12345678 one cycle after the commit edge; config_wr_pulse=16'h0004 for 1 cycle; BRESP=0.
- Preload slice 1 = 32'hFFFF_FFFF; write addr 0x04 data 32'hAABB_CCDD, WSTRB=4'b0101 -> slice 1 = 32'hFFBBFFDD.
- Drive status_in word 0 = 32'h0000_00A5; read addr 0x40 (idx 16) -> RDATA=32'hA5, RRESP=0. Then write 0x40 -> BRESP=2'b10, no pulse, read back is still status.
- Read addr 0x60 (idx 24, illegal) -> RDATA=0, RRESP=2'b10. Hold RREADY=0 for 5 cycles -> RVALID and RDATA stay stable and ARREADY=0 throughout.
- Assert S_AXI_ARESET while aw_held=1 and w_held=0 after an AW handshake to addr 0x00 -> after reset, slice 0 = CONFIG_RESET slice 0, BVALID=0, AWREADY=1, and a fresh full write completes normally.
